signal_gen_ctrl: RTL and testbench

//   Programmable square-wave/PWM burst generator; transmit-side counterpart of the period/duty

---
 rtl/signal_gen_ctrl.sv | 125 ++++++++++++
 tb/tb_signal_gen_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/signal_gen_ctrl.sv
// signal_gen_ctrl: programmable square-wave / PWM burst generator.
// Drives sig_out with a period of P clocks and a high time of H clocks. It runs for
// N periods, or until stop when N is 0.
// Optional build macro SIG_GEN_SHADOW_EN: period_in/high_in are re-sampled on every
// period wrap. The new values apply from the start of the next period.
// Without the macro, P and H are latched only when a burst starts.
//
// state | meaning
// IDLE  | waiting for enable; outputs low
// RUN   | generating periods; busy high

module signal_gen_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int PERIOD_W = 26,
  parameter int HIGH_W   = 20,
  parameter int CYC_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic [HIGH_W-1:0]   high_in,
  input  logic [CYC_W-1:0]    cycles_in,
  output logic                sig_out,
  output logic                busy,
  output logic                finish,
  output logic [CYC_W-1:0]    cycle_cnt
);

  // Elaboration-time sanity checks on the parameters.
  if (CLK_FREQ <= 0) begin : g_bad_clk_freq
    $error("signal_gen_ctrl: CLK_FREQ must be positive");
  end
  if (PERIOD_W < HIGH_W) begin : g_bad_widths
    $error("signal_gen_ctrl: PERIOD_W must be at least HIGH_W");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] p_reg;
  logic [PERIOD_W-1:0] h_reg;
  logic [PERIOD_W-1:0] pcnt;
  logic [CYC_W-1:0]    n_reg;

  logic [PERIOD_W-1:0] h_ext;
  logic [PERIOD_W-1:0] p_new;
  logic [PERIOD_W-1:0] h_new;
  logic [PERIOD_W-1:0] pcnt_next;
  logic [CYC_W-1:0]    cnt_next;
  logic                last_pos;
  logic                burst_done;

  // Clamp the requested period/high time, and decode the end of a period and the end of a burst.
  always_comb begin
    h_ext      = PERIOD_W'(high_in);
    p_new      = (period_in < PERIOD_W'(2)) ? PERIOD_W'(2) : period_in;
    h_new      = (h_ext > (p_new - PERIOD_W'(1))) ? (p_new - PERIOD_W'(1)) : h_ext;
    pcnt_next  = pcnt + PERIOD_W'(1);
    cnt_next   = cycle_cnt + CYC_W'(1);
    last_pos   = (pcnt == (p_reg - PERIOD_W'(1)));
    burst_done = (n_reg != '0) && (cnt_next == n_reg);
  end

  // Burst FSM; all outputs registered so sig_out is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p_reg     <= '0;
      h_reg     <= '0;
      pcnt      <= '0;
      n_reg     <= '0;
      cycle_cnt <= '0;
      sig_out   <= 1'b0;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !stop) begin
            state     <= RUN;
            p_reg     <= p_new;
            h_reg     <= h_new;
            n_reg     <= cycles_in;
            pcnt      <= '0;
            cycle_cnt <= '0;
            busy      <= 1'b1;
            sig_out   <= (h_new != '0);
          end
        end
        RUN: begin
          if (stop) begin
            // Abort: the period count freezes and no finish pulse is raised.
            state   <= IDLE;
            busy    <= 1'b0;
            sig_out <= 1'b0;
          end else if (last_pos) begin
            cycle_cnt <= cnt_next;
            pcnt      <= '0;
            if (burst_done) begin
              state   <= IDLE;
              busy    <= 1'b0;
              sig_out <= 1'b0;
              finish  <= 1'b1;
            end else begin
`ifdef SIG_GEN_SHADOW_EN
              p_reg   <= p_new;
              h_reg   <= h_new;
              sig_out <= (h_new != '0);
`else
              sig_out <= (h_reg != '0);
`endif
            end
          end else begin
            pcnt    <= pcnt_next;
            sig_out <= (pcnt_next < h_reg);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_gen_ctrl.sv
// Testbench for signal_gen_ctrl: table-driven bursts plus hand-written corner sequences.
module tb_signal_gen_ctrl;
  localparam int PW = 26;
  localparam int HW = 20;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          stop;
  logic [PW-1:0] period_in;
  logic [HW-1:0] high_in;
  logic [CW-1:0] cycles_in;
  logic          sig_out;
  logic          busy;
  logic          finish;
  logic [CW-1:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  signal_gen_ctrl #(.PERIOD_W(PW), .HIGH_W(HW), .CYC_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .stop(stop),
    .period_in(period_in), .high_in(high_in), .cycles_in(cycles_in),
    .sig_out(sig_out), .busy(busy), .finish(finish), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] period;
    logic [HW-1:0] high;
    logic [CW-1:0] cycles;
    int            ep;
    int            eh;
    int            en;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_burst(input logic [PW-1:0] p, input logic [HW-1:0] h, input logic [CW-1:0] n);
    @(negedge clk);
    period_in = p;
    high_in   = h;
    cycles_in = n;
    enable    = 1'b1;
    @(negedge clk);
    enable    = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    start_burst(v.period, v.high, v.cycles);
    cycles_in = 8'd0;
`ifndef SIG_GEN_SHADOW_EN
    period_in = 26'd7;
    high_in   = 20'd1;
`endif
    for (int i = 0; i < v.ep * v.en; i++) begin
      check($sformatf("v%0d sig_out c%0d", idx, i), sig_out, ((i % v.ep) < v.eh) ? 1 : 0);
      check($sformatf("v%0d busy c%0d", idx, i), busy, 1);
      check($sformatf("v%0d finish c%0d", idx, i), finish, 0);
      check($sformatf("v%0d cycle_cnt c%0d", idx, i), cycle_cnt, i / v.ep);
      if (i == 1) enable = 1'b1;
      if (i == 2) enable = 1'b0;
      @(negedge clk);
    end
    check($sformatf("v%0d finish end", idx), finish, 1);
    check($sformatf("v%0d busy end", idx), busy, 0);
    check($sformatf("v%0d sig_out end", idx), sig_out, 0);
    check($sformatf("v%0d cycle_cnt end", idx), cycle_cnt, v.en);
    @(negedge clk);
    check($sformatf("v%0d finish after", idx), finish, 0);
    check($sformatf("v%0d busy after", idx), busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    //        period     high          cycles  P   H  N
    vecs[0] = '{26'd10, 20'd3,       8'd2,   10, 3, 2};
    vecs[1] = '{26'd10, 20'd0,       8'd1,   10, 0, 1};
    vecs[2] = '{26'd10, 20'd12,      8'd1,   10, 9, 1};
    vecs[3] = '{26'd1,  20'd1,       8'd3,   2,  1, 3};
    vecs[4] = '{26'd0,  20'd5,       8'd2,   2,  1, 2};
    vecs[5] = '{26'd5,  20'd5,       8'd1,   5,  4, 1};
    vecs[6] = '{26'd3,  20'hFFFFF,   8'd2,   3,  2, 2};
    vecs[7] = '{26'd2,  20'd1,       8'd255, 2,  1, 255};

    rst = 1'b1; enable = 1'b0; stop = 1'b0;
    period_in = '0; high_in = '0; cycles_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset sig_out", sig_out, 0);
    check("reset busy", busy, 0);
    check("reset finish", finish, 0);
    check("reset cycle_cnt", cycle_cnt, 0);

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Continuous mode: 300 periods, counter wraps past 255, then stop.
    start_burst(26'd4, 20'd2, 8'd0);
    for (int i = 0; i < 1200; i++) begin
      check($sformatf("cont sig_out c%0d", i), sig_out, ((i % 4) < 2) ? 1 : 0);
      check($sformatf("cont cycle_cnt c%0d", i), cycle_cnt, (i / 4) % 256);
      check($sformatf("cont finish c%0d", i), finish, 0);
      @(negedge clk);
    end
    check("cont cycle_cnt 300", cycle_cnt, 44);
    check("cont sig_out before stop", sig_out, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop sig_out", sig_out, 0);
    check("stop busy", busy, 0);
    check("stop finish", finish, 0);
    check("stop cycle_cnt hold", cycle_cnt, 44);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("after stop finish c%0d", i), finish, 0);
      check($sformatf("after stop busy c%0d", i), busy, 0);
    end

    // Stop on the same edge as the last-period wrap: stop wins.
    start_burst(26'd4, 20'd2, 8'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lastwrap sig_out c%0d", i), sig_out, (i < 2) ? 1 : 0);
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("lastwrap finish", finish, 0);
    check("lastwrap busy", busy, 0);
    check("lastwrap sig_out", sig_out, 0);
    check("lastwrap cycle_cnt", cycle_cnt, 0);
    @(negedge clk);
    check("lastwrap finish later", finish, 0);

    // Reset in the middle of a burst.
    start_burst(26'd10, 20'd3, 8'd5);
    repeat (12) @(negedge clk);
    check("prerst sig_out", sig_out, 1);
    check("prerst cycle_cnt", cycle_cnt, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst sig_out", sig_out, 0);
    check("midrst busy", busy, 0);
    check("midrst finish", finish, 0);
    check("midrst cycle_cnt", cycle_cnt, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check($sformatf("postrst busy c%0d", i), busy, 0);
      check($sformatf("postrst finish c%0d", i), finish, 0);
    end

    // Enable and stop together while idle: no start.
    period_in = 26'd4; high_in = 20'd2; cycles_in = 8'd1;
    enable = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("en+stop busy c%0d", i), busy, 0);
      check($sformatf("en+stop sig_out c%0d", i), sig_out, 0);
    end
    enable = 1'b0; stop = 1'b0;
    @(negedge clk);

    // Live retune mid-period; only takes effect with the shadow build.
    begin
      int total;
`ifdef SIG_GEN_SHADOW_EN
      total = 20;
`else
      total = 24;
`endif
      start_burst(26'd8, 20'd4, 8'd3);
      for (int i = 0; i < total; i++) begin
        logic e;
`ifdef SIG_GEN_SHADOW_EN
        e = (i < 8) ? (i < 4) : (((i - 8) % 6) < 1);
`else
        e = (i % 8) < 4;
`endif
        check($sformatf("retune sig_out c%0d", i), sig_out, e ? 1 : 0);
        check($sformatf("retune busy c%0d", i), busy, 1);
        if (i == 2) begin
          period_in = 26'd6;
          high_in   = 20'd1;
        end
        @(negedge clk);
      end
      check("retune finish", finish, 1);
      check("retune cycle_cnt", cycle_cnt, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
